// File: rtl/led_scan_timing_gen.sv
// LED panel scan/timing generator: drives panel CLK/LAT/OE, the row address,
// the PWM plane code for the pixel decoder and the AL422 read-reset strobe.
// Ports:
//   in_clk, in_rst       clock, asynchronous active-high reset
//   pix_strobe           one pixel column shifted this cycle
//   pwm_req, alrst_req   decoder requests: advance PWM plane / rewind AL422
//   brightness           global brightness, 0 = dark, shadowed per row
//   led_clk_out/_lat_out/_oe_out  panel pins after polarity selection
//   led_row              row address, upper unused bits held 0
//   pwm_code             plane code (bit-reversed when DITHER)
//   al422_nrst           AL422 read reset, active low
//   frame_start          one-cycle pulse when the PWM counter wraps
module led_scan_timing_gen #(
   parameter int unsigned PIXEL_COUNT    = 64,
   parameter int unsigned SCAN_ROWS      = 8,
   parameter int unsigned PWM_W          = 6,
   parameter int unsigned PRELOAD        = 1,
   parameter int unsigned PWM_CORR       = 0,
   parameter int unsigned OE_PREDELAY    = 2,
   parameter int unsigned OE_POSTDELAY   = 2,
   parameter int unsigned BRI_W          = 4,
   parameter int unsigned DITHER         = 1,
   parameter int unsigned OE_ACTIVE_LOW  = 1,
   parameter int unsigned CLK_ON_FALL    = 0,
   parameter int unsigned LAT_ACTIVE_LOW = 0
) (
   input  logic             in_clk,
   input  logic             in_rst,
   input  logic             pix_strobe,
   input  logic             pwm_req,
   input  logic             alrst_req,
   input  logic [BRI_W-1:0] brightness,
   output logic             led_clk_out,
   output logic             led_lat_out,
   output logic             led_oe_out,
   output logic [4:0]       led_row,
   output logic [PWM_W-1:0] pwm_code,
   output logic             al422_nrst,
   output logic             frame_start
);

   localparam int unsigned CW      = (PIXEL_COUNT > 1) ? $clog2(PIXEL_COUNT) : 1;
   localparam int unsigned RW      = $clog2(SCAN_ROWS);
   localparam int unsigned PW      = CW + BRI_W + 1;
   localparam int unsigned P0      = (PIXEL_COUNT - PRELOAD) % PIXEL_COUNT;
   localparam int unsigned P0_M1   = (P0 + PIXEL_COUNT - 1) % PIXEL_COUNT;
   localparam int unsigned PWM_PIX = (P0 + PWM_CORR) % PIXEL_COUNT;
   localparam int unsigned WIN     = PIXEL_COUNT - OE_PREDELAY - OE_POSTDELAY;
   localparam int unsigned MAXP    = (2 ** PWM_W) - 2;

   logic [CW-1:0]    r_pix_cnt;
   logic [RW-1:0]    r_row;
   logic [BRI_W-1:0] r_bri_sh;
   logic             r_oe;
   logic [PWM_W-1:0] r_pwm_cnt;
   logic             r_frame_start;
   logic             r_al422_nrst;

   logic             w_lat;
   logic             w_row_pre_last;
   logic [PW-1:0]    w_prod;
   logic [CW-1:0]    w_off_pix;
   logic             w_oe_set;
   logic             w_oe_clr;
   logic             w_pwm_adv;
   logic             w_pwm_wrap;
   logic             w_alrst;
   logic [PWM_W-1:0] w_pwm_rev;

   // Row strobes and qualifiers
   assign w_lat          = pix_strobe & (r_pix_cnt == CW'(PIXEL_COUNT - 1));
   assign w_row_pre_last = (r_row == RW'(SCAN_ROWS - 2));

   // OE window end: full-width product so no brightness step is lost
   assign w_prod    = PW'(WIN) * (PW'(r_bri_sh) + PW'(1));
   assign w_off_pix = CW'(PW'(OE_POSTDELAY) + (w_prod >> BRI_W));
   assign w_oe_set  = (r_pix_cnt == CW'(OE_POSTDELAY)) & (r_bri_sh != '0);
   assign w_oe_clr  = (r_pix_cnt == w_off_pix);

   assign w_pwm_adv  = pwm_req & (r_pix_cnt == CW'(PWM_PIX)) & w_row_pre_last;
   assign w_pwm_wrap = w_pwm_adv & (r_pwm_cnt == PWM_W'(MAXP));
   assign w_alrst    = alrst_req & (r_pix_cnt == CW'(P0_M1)) & w_row_pre_last;

   // Pixel counter, preloaded to absorb the decoder pipeline
   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         r_pix_cnt <= CW'(P0);
      end else if (pix_strobe) begin
         r_pix_cnt <= (r_pix_cnt == CW'(PIXEL_COUNT - 1)) ? '0 : r_pix_cnt + CW'(1);
      end
   end

   // Row counter and brightness shadow, both advanced by LAT
   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         r_row    <= RW'(SCAN_ROWS - 2);
         r_bri_sh <= '1;
      end else if (w_lat) begin
         r_row    <= (r_row == RW'(SCAN_ROWS - 1)) ? '0 : r_row + RW'(1);
         r_bri_sh <= brightness;
      end
   end

   // OE window; clear has priority, dark brightness forces it off
   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         r_oe <= 1'b0;
      end else if (w_oe_clr || (r_bri_sh == '0)) begin
         r_oe <= 1'b0;
      end else if (w_oe_set) begin
         r_oe <= 1'b1;
      end
   end

   // PWM plane counter, skips the all-ones code
   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         r_pwm_cnt     <= PWM_W'(MAXP);
         r_frame_start <= 1'b0;
         r_al422_nrst  <= 1'b1;
      end else begin
         if (w_pwm_adv) begin
            r_pwm_cnt <= w_pwm_wrap ? '0 : r_pwm_cnt + PWM_W'(1);
         end
         r_frame_start <= w_pwm_wrap;
         r_al422_nrst  <= ~w_alrst;
      end
   end

   // Bit reversal spreads the PWM planes in time
   always_comb begin
      w_pwm_rev = '0;
      for (int i = 0; i < int'(PWM_W); i++) begin
         w_pwm_rev[i] = r_pwm_cnt[PWM_W-1-i];
      end
   end

   assign pwm_code    = (DITHER != 0) ? w_pwm_rev : r_pwm_cnt;
   assign led_row     = 5'(r_row);
   assign frame_start = r_frame_start;
   assign al422_nrst  = r_al422_nrst;
   assign led_clk_out = (CLK_ON_FALL != 0)    ? ~pix_strobe : pix_strobe;
   assign led_lat_out = (LAT_ACTIVE_LOW != 0) ? ~w_lat      : w_lat;
   assign led_oe_out  = (OE_ACTIVE_LOW != 0)  ? ~r_oe       : r_oe;

endmodule

// File: tb/tb_led_scan_timing_gen.sv
// Directed bench for led_scan_timing_gen: default, non-dithered and
// 128x32/8-bit instances share stimulus; each test resets first.
module tb_led_scan_timing_gen;

   logic       in_clk;
   logic       in_rst;
   logic       pix_strobe;
   logic       pwm_req;
   logic       alrst_req;
   logic [3:0] brightness;

   logic a_clk, a_lat, a_oe, a_nrst, a_fs;
   logic n_clk, n_lat, n_oe, n_nrst, n_fs;
   logic b_clk, b_lat, b_oe, b_nrst, b_fs;
   logic [4:0] a_row, n_row, b_row;
   logic [5:0] a_pwm, n_pwm;
   logic [7:0] b_pwm;

   int checks   = 0;
   int failures = 0;

   led_scan_timing_gen u_dut (
      .in_clk(in_clk), .in_rst(in_rst), .pix_strobe(pix_strobe), .pwm_req(pwm_req),
      .alrst_req(alrst_req), .brightness(brightness), .led_clk_out(a_clk),
      .led_lat_out(a_lat), .led_oe_out(a_oe), .led_row(a_row), .pwm_code(a_pwm),
      .al422_nrst(a_nrst), .frame_start(a_fs));

   led_scan_timing_gen #(.DITHER(0)) u_nd (
      .in_clk(in_clk), .in_rst(in_rst), .pix_strobe(pix_strobe), .pwm_req(pwm_req),
      .alrst_req(alrst_req), .brightness(brightness), .led_clk_out(n_clk),
      .led_lat_out(n_lat), .led_oe_out(n_oe), .led_row(n_row), .pwm_code(n_pwm),
      .al422_nrst(n_nrst), .frame_start(n_fs));

   led_scan_timing_gen #(.PIXEL_COUNT(128), .SCAN_ROWS(32), .PWM_W(8), .DITHER(0)) u_big (
      .in_clk(in_clk), .in_rst(in_rst), .pix_strobe(pix_strobe), .pwm_req(pwm_req),
      .alrst_req(alrst_req), .brightness(brightness), .led_clk_out(b_clk),
      .led_lat_out(b_lat), .led_oe_out(b_oe), .led_row(b_row), .pwm_code(b_pwm),
      .al422_nrst(b_nrst), .frame_start(b_fs));

   initial in_clk = 1'b0;
   always #5 in_clk = ~in_clk;

   function automatic logic [5:0] bitrev6(input logic [5:0] v);
      logic [5:0] r;
      for (int i = 0; i < 6; i++) r[i] = v[5-i];
      return r;
   endfunction

   task automatic do_reset(input logic [3:0] bri);
      in_rst = 1'b1; pix_strobe = 1'b0; pwm_req = 1'b0; alrst_req = 1'b0;
      brightness = bri;
      repeat (2) @(posedge in_clk);
      #1 in_rst = 1'b0;
   endtask

   task automatic test_reset;
      in_rst = 1'b1; pix_strobe = 1'b0; pwm_req = 1'b0; alrst_req = 1'b0; brightness = 4'd15;
      @(posedge in_clk); #1;
      checks++; if (a_row !== 5'd6) begin failures++; $display("FAIL reset_row got=%0d exp=6", a_row); end
      checks++; if (a_pwm !== 6'b011111) begin failures++; $display("FAIL reset_pwm got=%b exp=011111", a_pwm); end
      checks++; if ({a_clk, a_lat, a_oe, a_nrst, a_fs} !== 5'b00110) begin failures++; $display("FAIL reset_pins got=%b exp=00110", {a_clk, a_lat, a_oe, a_nrst, a_fs}); end
      checks++; if ({n_clk, n_lat, n_oe, n_nrst, n_fs} !== 5'b00110) begin failures++; $display("FAIL reset_nd_pins got=%b exp=00110", {n_clk, n_lat, n_oe, n_nrst, n_fs}); end
      checks++; if (n_pwm !== 6'd62 || n_row !== 5'd6) begin failures++; $display("FAIL reset_nd_pwm_row got=%0d/%0d exp=62/6", n_pwm, n_row); end
      checks++; if (b_row !== 5'd30 || b_pwm !== 8'd254) begin failures++; $display("FAIL reset_big_row_pwm got=%0d/%0d exp=30/254", b_row, b_pwm); end
      checks++; if ({b_clk, b_lat, b_oe, b_nrst, b_fs} !== 5'b00110) begin failures++; $display("FAIL reset_big_pins got=%b exp=00110", {b_clk, b_lat, b_oe, b_nrst, b_fs}); end
      in_rst = 1'b0;
      repeat (5) @(posedge in_clk); #1;
      checks++; if (a_row !== 5'd6 || a_pwm !== 6'b011111 || a_oe !== 1'b1 || a_nrst !== 1'b1) begin
         failures++; $display("FAIL reset_hold got row=%0d pwm=%b oe=%b nrst=%b exp 6/011111/1/1", a_row, a_pwm, a_oe, a_nrst); end
      pix_strobe = 1'b1; #1;
      checks++; if (a_clk !== 1'b1 || a_lat !== 1'b1) begin failures++; $display("FAIL first_strobe_clk_lat got=%b%b exp=11", a_clk, a_lat); end
      checks++; if (b_lat !== 1'b1) begin failures++; $display("FAIL first_strobe_big_lat got=%b exp=1", b_lat); end
      checks++; if (a_row !== 5'd6) begin failures++; $display("FAIL row_before_edge got=%0d exp=6", a_row); end
      @(posedge in_clk); #1; pix_strobe = 1'b0; #1;
      checks++; if (a_row !== 5'd7 || a_lat !== 1'b0 || a_clk !== 1'b0) begin
         failures++; $display("FAIL row_after_lat got row=%0d lat=%b clk=%b exp 7/0/0", a_row, a_lat, a_clk); end
   endtask

   task automatic test_lat_row;
      int lat_cnt;
      logic exp_lat;
      lat_cnt = 0;
      do_reset(4'd15);
      for (int k = 1; k <= 129; k++) begin
         pix_strobe = 1'b1; #1;
         exp_lat = (((63 + k - 1) % 64) == 63);
         checks++; if (a_lat !== exp_lat) begin failures++; $display("FAIL lat_strobe%0d got=%b exp=%b", k, a_lat, exp_lat); end
         if (a_lat === 1'b1) lat_cnt++;
         if (k == 65) begin
            checks++; if (a_row !== 5'd7) begin failures++; $display("FAIL row_hold_at_lat got=%0d exp=7", a_row); end
         end
         @(posedge in_clk); #1;
         if (k == 1) begin checks++; if (a_row !== 5'd7) begin failures++; $display("FAIL row_k1 got=%0d exp=7", a_row); end end
         if (k == 65) begin checks++; if (a_row !== 5'd0) begin failures++; $display("FAIL row_wrap got=%0d exp=0", a_row); end end
         if (k == 129) begin checks++; if (a_row !== 5'd1) begin failures++; $display("FAIL row_k129 got=%0d exp=1", a_row); end end
      end
      pix_strobe = 1'b0;
      checks++; if (lat_cnt != 3) begin failures++; $display("FAIL lat_count got=%0d exp=3", lat_cnt); end
   endtask

   task automatic test_oe(input logic [3:0] bri, input int hi);
      int c;
      logic exp_pin;
      do_reset(bri);
      for (int k = 1; k <= 64; k++) begin
         pix_strobe = 1'b1;
         @(posedge in_clk); #1;
         c = (63 + k) % 64;
         exp_pin = !(hi != 0 && c >= 3 && c <= hi);
         checks++; if (a_oe !== exp_pin) begin failures++; $display("FAIL oe_bri%0d_pix%0d got=%b exp=%b", bri, c, a_oe, exp_pin); end
      end
      pix_strobe = 1'b0;
   endtask

   task automatic test_bri_shadow;
      int c, hi;
      logic exp_pin;
      do_reset(4'd15);
      for (int k = 1; k <= 128; k++) begin
         pix_strobe = 1'b1;
         @(posedge in_clk); #1;
         c  = (63 + k) % 64;
         hi = (k <= 64) ? 62 : 17;
         exp_pin = !(c >= 3 && c <= hi);
         checks++; if (a_oe !== exp_pin) begin failures++; $display("FAIL bri_shadow_k%0d_pix%0d got=%b exp=%b", k, c, a_oe, exp_pin); end
         if (k <= 64 && c == 10) brightness = 4'd3;
      end
      pix_strobe = 1'b0;
   endtask

   task automatic test_pwm;
      int exp, fs_cnt;
      logic wrap;
      do_reset(4'd15);
      exp = 62; fs_cnt = 0;
      pwm_req = 1'b1; pix_strobe = 1'b1;
      for (int k = 1; k <= 32768; k++) begin
         @(posedge in_clk); #1;
         wrap = 1'b0;
         if ((k % 512) == 1) begin
            wrap = (exp == 62);
            exp  = wrap ? 0 : exp + 1;
         end
         if (a_fs === 1'b1) fs_cnt++;
         checks++; if (n_pwm !== 6'(exp) || n_pwm === 6'd63) begin failures++; $display("FAIL pwm_nd_k%0d got=%0d exp=%0d", k, n_pwm, exp); end
         checks++; if (a_pwm !== bitrev6(6'(exp))) begin failures++; $display("FAIL pwm_dither_k%0d got=%b exp=%b", k, a_pwm, bitrev6(6'(exp))); end
         checks++; if (a_fs !== wrap) begin failures++; $display("FAIL frame_start_k%0d got=%b exp=%b", k, a_fs, wrap); end
      end
      pwm_req = 1'b0; pix_strobe = 1'b0;
      checks++; if (fs_cnt != 2) begin failures++; $display("FAIL frame_start_count got=%0d exp=2", fs_cnt); end
   endtask

   task automatic test_alrst;
      do_reset(4'd15);
      pix_strobe = 1'b1;
      repeat (447) @(posedge in_clk);
      #1 pix_strobe = 1'b0;
      checks++; if (a_row !== 5'd5) begin failures++; $display("FAIL alrst_row5 got=%0d exp=5", a_row); end
      alrst_req = 1'b1;
      @(posedge in_clk); #1; alrst_req = 1'b0;
      checks++; if (a_nrst !== 1'b1) begin failures++; $display("FAIL alrst_wrong_row got=%b exp=1", a_nrst); end
      pix_strobe = 1'b1;
      repeat (64) @(posedge in_clk);
      #1 pix_strobe = 1'b0;
      checks++; if (a_row !== 5'd6) begin failures++; $display("FAIL alrst_row6 got=%0d exp=6", a_row); end
      alrst_req = 1'b1; #1;
      checks++; if (a_nrst !== 1'b1) begin failures++; $display("FAIL alrst_early got=%b exp=1", a_nrst); end
      @(posedge in_clk); #1; alrst_req = 1'b0;
      checks++; if (a_nrst !== 1'b0) begin failures++; $display("FAIL alrst_pulse got=%b exp=0", a_nrst); end
      @(posedge in_clk); #1;
      checks++; if (a_nrst !== 1'b1) begin failures++; $display("FAIL alrst_release got=%b exp=1", a_nrst); end
      alrst_req = 1'b1;
      @(posedge in_clk); #1;
      checks++; if (a_nrst !== 1'b0) begin failures++; $display("FAIL alrst_consec1 got=%b exp=0", a_nrst); end
      @(posedge in_clk); #1; alrst_req = 1'b0;
      checks++; if (a_nrst !== 1'b0) begin failures++; $display("FAIL alrst_consec2 got=%b exp=0", a_nrst); end
      @(posedge in_clk); #1;
      checks++; if (a_nrst !== 1'b1) begin failures++; $display("FAIL alrst_consec_end got=%b exp=1", a_nrst); end
   endtask

   task automatic test_mid_reset;
      do_reset(4'd15);
      pix_strobe = 1'b1;
      repeat (20) @(posedge in_clk);
      #1;
      checks++; if (a_oe !== 1'b0 || a_row !== 5'd7) begin failures++; $display("FAIL mid_pre got oe=%b row=%0d exp 0/7", a_oe, a_row); end
      #2 in_rst = 1'b1; pix_strobe = 1'b0;
      #1;
      checks++; if (a_oe !== 1'b1 || a_row !== 5'd6 || a_pwm !== 6'b011111 || a_nrst !== 1'b1 || a_lat !== 1'b0 || a_clk !== 1'b0) begin
         failures++; $display("FAIL mid_reset got oe=%b row=%0d pwm=%b nrst=%b lat=%b clk=%b exp 1/6/011111/1/0/0", a_oe, a_row, a_pwm, a_nrst, a_lat, a_clk); end
      @(posedge in_clk); #1 in_rst = 1'b0;
   endtask

   task automatic test_sweep;
      do_reset(4'd15);
      pwm_req = 1'b1; pix_strobe = 1'b1; #1;
      checks++; if (b_lat !== 1'b1) begin failures++; $display("FAIL big_lat1 got=%b exp=1", b_lat); end
      @(posedge in_clk); #1; pwm_req = 1'b0;
      checks++; if (b_row !== 5'd31 || b_row[4] !== 1'b1) begin failures++; $display("FAIL big_row31 got=%0d exp=31", b_row); end
      checks++; if (b_pwm !== 8'd0 || b_fs !== 1'b1) begin failures++; $display("FAIL big_pwm_wrap got=%0d fs=%b exp 0/1", b_pwm, b_fs); end
      for (int k = 2; k <= 129; k++) begin
         if (k == 129) begin
            checks++; if (b_lat !== 1'b1 || b_row !== 5'd31) begin failures++; $display("FAIL big_lat2 got lat=%b row=%0d exp 1/31", b_lat, b_row); end
         end
         @(posedge in_clk); #1;
      end
      pix_strobe = 1'b0;
      checks++; if (b_row !== 5'd0 || b_fs !== 1'b0 || b_pwm !== 8'd0) begin
         failures++; $display("FAIL big_row_wrap got row=%0d fs=%b pwm=%0d exp 0/0/0", b_row, b_fs, b_pwm); end
   endtask

   initial begin
      test_reset;
      test_lat_row;
      test_oe(4'd15, 62);
      test_oe(4'd7, 32);
      test_oe(4'd0, 0);
      test_bri_shadow;
      test_alrst;
      test_mid_reset;
      test_sweep;
      test_pwm;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
